// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: two-requester round-robin front end for a shared iterative fp divider.
//
// One operation is in flight at a time. An accepted request is latched, launched
// with a single div_start pulse, waited on while div_busy is high (bounded by a
// watchdog), drained for DRAIN_CYC cycles so the divider output settles, and the
// result is held in RESP until the consumer takes it.
//
// Ports
//   clk, rstn                   clock, synchronous active-low reset
//   req_valid/req_ready [1:0]   per-requester handshake (bit i = requester i)
//   req_a*/req_b*/req_rm*       operands and round mode per requester
//   div_a/div_b/div_rm          latched operands to the divider
//   div_start/div_ena           launch pulse and pipeline enable to the divider
//   div_busy/div_s/div_err      divider status, result and error code
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_data/rsp_err     requester index, quotient, error code
//   rsp_timeout                 operation aborted by the WAIT watchdog
//   busy_o                      high in any state other than IDLE
module fdiv_arbiter #(
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned TIMEOUT   = 31,
    parameter int unsigned ERR_W     = 3
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b1,
    input  logic [1:0]       req_rm0,
    input  logic [1:0]       req_rm1,

    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic [1:0]       div_rm,
    output logic             div_start,
    output logic             div_ena,
    input  logic             div_busy,
    input  logic [31:0]      div_s,
    input  logic [ERR_W-1:0] div_err,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic [ERR_W-1:0] rsp_err,
    output logic             rsp_timeout,
    output logic             busy_o
);

    // WAIT counter is at least 5 bits wide and always large enough for TIMEOUT-1.
    localparam int unsigned WCNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    // TIMEOUT is expected to be at least 1.
    localparam logic [WCNT_W-1:0] WaitLast  = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WaitOne   = WCNT_W'(1);
    localparam logic [DCNT_W-1:0] DrainLast = DCNT_W'(DRAIN_CYC - 1);
    localparam logic [DCNT_W-1:0] DrainOne  = DCNT_W'(1);

    // Canonical quiet NaN returned on a watchdog abort.
    localparam logic [31:0] QNaN = 32'h7fc0_0000;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StDrain,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [1:0]        op_rm_q, op_rm_d;
    logic              op_id_q, op_id_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [ERR_W-1:0]  rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic [1:0]        grant;
    logic              accept;
    logic              accept_id;

    // Round-robin pick: a lone requester always wins; on contention the one not
    // granted last time wins. last_grant_q holds the index of the last winner.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Offer a grant only while idle and out of reset.
    assign req_ready = (state_q == StIdle && rstn) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign accept_id = req_ready[1];

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_rm_d       = op_rm_q;
        op_id_d       = op_id_q;
        wait_cnt_d    = wait_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        div_start     = 1'b0;
        div_ena       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_a_d       = accept_id ? req_a1 : req_a0;
                    op_b_d       = accept_id ? req_b1 : req_b0;
                    op_rm_d      = accept_id ? req_rm1 : req_rm0;
                    op_id_d      = accept_id;
                    last_grant_d = accept_id;
                    state_d      = StLaunch;
                end
            end

            StLaunch: begin
                div_start  = 1'b1;
                div_ena    = 1'b1;
                wait_cnt_d = '0;
                state_d    = StWait;
            end

            StWait: begin
                div_ena = 1'b1;
                if (!div_busy) begin
                    if (DRAIN_CYC == 0) begin
                        // No settling time: take the result in the cycle busy drops.
                        rsp_data_d    = div_s;
                        rsp_err_d     = div_err;
                        rsp_timeout_d = 1'b0;
                        state_d       = StResp;
                    end else begin
                        drain_cnt_d = '0;
                        state_d     = StDrain;
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    // TIMEOUT WAIT cycles with busy still high: abort with a qNaN.
                    rsp_data_d    = QNaN;
                    rsp_err_d     = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitOne;
                end
            end

            StDrain: begin
                div_ena = 1'b1;
                if (drain_cnt_q == DrainLast) begin
                    rsp_data_d    = div_s;
                    rsp_err_d     = div_err;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainOne;
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;  // requester 0 wins the first contention
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_rm_q       <= '0;
            op_id_q       <= 1'b0;
            wait_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_rm_q       <= op_rm_d;
            op_id_q       <= op_id_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Operand registers only change on accept, so the divider inputs show the
    // latched operation from LAUNCH onward and keep it until the next accept.
    assign div_a       = op_a_q;
    assign div_b       = op_b_q;
    assign div_rm      = op_rm_q;

    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = op_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter DRAIN_CYC, default 3, SHALL set the cycles waited after div_busy falls before the result is sampled.
REQ-002 Parameter TIMEOUT, default 31, SHALL set the maximum WAIT-state cycles before the operation is aborted.
REQ-003 Parameter ERR_W, default 3, SHALL set the width of the error code.
REQ-004 Ports SHALL be as follows, one per line:
- clk  in  1  clock, all state on posedge; one clock, synchronous active-low reset
- rstn  in  1  synchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept
- req_a0, req_b0, req_a1, req_b1  in  32  dividend and divisor per requester
- req_rm0, req_rm1  in  2  round mode per requester
- div_a, div_b  out  32  operands to the divider
- div_rm  out  2  round mode to the divider
- div_start  out  1  divider fdiv launch pulse
- div_ena  out  1  divider pipeline enable
- div_busy  in  1  divider iteration busy
- div_s  in  32  divider result
- div_err  in  ERR_W  divider error code
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester index of the response
- rsp_data  out  32  quotient
- rsp_err  out  ERR_W  captured error code
- rsp_timeout  out  1  operation aborted by watchdog
- busy_o  out  1  high in any state other than IDLE

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, LAUNCH, WAIT, DRAIN and RESP.
REQ-006 In IDLE, req_ready SHALL be one-hot on the granted valid requester, combinational from req_valid and the pointer; req_ready SHALL be zero in all other states.
REQ-007 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-008 A grant SHALL update last_grant.
REQ-009 On req_valid & req_ready, the block SHALL latch the operands, rm and id, then go to LAUNCH on the next cycle.
REQ-010 div_a, div_b and div_rm SHALL drive the latched values from LAUNCH through DRAIN, and SHALL hold their last value otherwise.
REQ-011 LAUNCH SHALL last exactly 1 cycle with div_start=1 and div_ena=1, then go to WAIT.
REQ-012 WAIT SHALL assert div_ena=1 and div_start=0, last at least 1 cycle, and go to DRAIN on the first cycle div_busy=0.
REQ-013 A WAIT cycle counter (5 bits minimum) SHALL clear on entry; on reaching TIMEOUT with div_busy still 1, the block SHALL go to RESP with rsp_timeout=1, rsp_data=32'h7fc00000 and rsp_err=0.
REQ-014 DRAIN SHALL assert div_ena=1 for exactly DRAIN_CYC cycles; in the last DRAIN cycle the block SHALL register div_s and div_err into the response registers, then go to RESP.
REQ-015 DRAIN_CYC=0 SHALL capture in the cycle div_busy is seen low and go directly to RESP.
REQ-016 RESP SHALL hold rsp_valid=1 with rsp_id, rsp_data, rsp_err and rsp_timeout stable until rsp_ready=1.
REQ-017 On the rsp_ready=1 handshake the block SHALL return to IDLE; the next accept SHALL occur no earlier than the following cycle.
REQ-018 div_ena and div_start SHALL be 0 in IDLE and RESP.
REQ-019 req_valid deassertion after acceptance SHALL have no effect on the in-flight operation.
REQ-020 Throughput SHALL be at most one operation in flight; minimum latency from accept to rsp_valid SHALL be 1 (LAUNCH) + WAIT cycles + DRAIN_CYC + 1 cycles.

Reset
REQ-021 When rstn=0 at a posedge, the state SHALL become IDLE, last_grant SHALL become 1 (so requester 0 wins first), and all counters SHALL clear.
REQ-022 Reset SHALL force rsp_valid, rsp_id, rsp_data, rsp_err, rsp_timeout, div_start, div_ena, div_a, div_b, div_rm and busy_o to 0.
REQ-023 Reset mid-operation SHALL drop the in-flight operation with no response issued.
REQ-024 req_ready SHALL be 0 during reset.

Verification
REQ-025 Scenario 1: single req0, a=0x40400000, b=0x40000000, divider model busy for 6 cycles -> one div_start pulse, rsp_valid with rsp_id=0, rsp_data=0x3fc00000, rsp_timeout=0.
REQ-026 Scenario 2: req_valid=2'b11 held for 4 operations from reset -> grant order 0,1,0,1, with rsp_id matching each.
REQ-027 Scenario 3: rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, req_ready=0 throughout; then rsp_ready=1 -> IDLE next cycle.
REQ-028 Scenario 4: div_busy stuck at 1 -> rsp_valid after TIMEOUT WAIT cycles with rsp_timeout=1 and rsp_data=0x7fc00000.
REQ-029 Scenario 5: rstn=0 during DRAIN -> all outputs 0 next cycle and no rsp_valid; a new request afterwards is granted to requester 0.
REQ-030 Scenario 6: b=0 with div_err=DIVBYZERO code -> rsp_err equals that code and rsp_data equals the div_s sampled at the end of DRAIN.
